// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for decode and fetch: PC target encodings,
// fixed vectors and the fetch FSM state type.
package fetch_pkg;

    typedef enum logic [1:0] {
        SEL_PCIMD2EXT = 2'b00,
        SEL_REGA      = 2'b01,
        SEL_PCINDEX   = 2'b10,
        SEL_EXCEPTION = 2'b11
    } pc_sel_t;

    typedef enum logic {
        ST_RST   = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR     = 32'h0000_0000;
    localparam logic [31:0] EXCEPTION_VECTOR = 32'h0000_0040;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    // Sequential successor; wraps modulo 2^32 with no alignment check.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_pc_select.sv
// Redirect target mux: picks the new PC from the decode-supplied candidates
// or the fixed exception vector.
module pc_select
    import fetch_pkg::*;
(
    input  logic [1:0]  selpctype,
    input  logic [31:0] pcimd2ext,
    input  logic [31:0] rega,
    input  logic [31:0] pcindex,
    output logic [31:0] target
);

    always_comb begin
        target = pcimd2ext;
        case (pc_sel_t'(selpctype))
            SEL_PCIMD2EXT: target = pcimd2ext;
            SEL_REGA:      target = rega;
            SEL_PCINDEX:   target = pcindex;
            SEL_EXCEPTION: target = EXCEPTION_VECTOR;
            default:       target = pcimd2ext;
        endcase
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: drives the instruction-memory request from the PC,
// fills the IF/ID register and applies delayed-branch redirects.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RST   | just out of reset, no memory request, waiting one edge
// ST_FETCH | request at pc every cycle; ready completes it into IF/ID
module fetch
    import fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        id_if_selpcsource,
    input  logic [1:0]  id_if_selpctype,
    input  logic [31:0] id_if_pcimd2ext,
    input  logic [31:0] id_if_rega,
    input  logic [31:0] id_if_pcindex,
    output logic        if_mc_en,
    output logic [31:0] if_mc_addr,
    input  logic [31:0] mc_if_data,
    input  logic        mc_if_ready,
    output logic [31:0] if_id_instruc,
    output logic [31:0] if_id_nextpc
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  pend_pc, pend_pc_nxt;
    logic         pend_valid, pend_valid_nxt;
    logic [31:0]  instruc_nxt, nextpc_nxt;
    logic [31:0]  target;
    logic [31:0]  seq_pc;

    pc_select u_pc_select (
        .selpctype (id_if_selpctype),
        .pcimd2ext (id_if_pcimd2ext),
        .rega      (id_if_rega),
        .pcindex   (id_if_pcindex),
        .target    (target)
    );

    assign seq_pc     = next_seq_pc(pc);
    assign if_mc_addr = pc;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_pc_nxt    = pend_pc;
        pend_valid_nxt = pend_valid;
        instruc_nxt    = if_id_instruc;
        nextpc_nxt     = if_id_nextpc;
        if_mc_en       = 1'b0;

        case (state)
            ST_RST: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if_mc_en = 1'b1;
                if (mc_if_ready) begin
                    // The word arriving now is the delay slot of any redirect,
                    // so it is always delivered; a live redirect beats a pending one.
                    instruc_nxt    = mc_if_data;
                    nextpc_nxt     = seq_pc;
                    pend_valid_nxt = 1'b0;
                    if (id_if_selpcsource) begin
                        pc_nxt = target;
                    end else if (pend_valid) begin
                        pc_nxt = pend_pc;
                    end else begin
                        pc_nxt = seq_pc;
                    end
                end else begin
                    instruc_nxt = NOP_WORD;
                    if (id_if_selpcsource) begin
                        pend_pc_nxt    = target;
                        pend_valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_RST;
            pc            <= RESET_VECTOR;
            pend_pc       <= 32'h0000_0000;
            pend_valid    <= 1'b0;
            if_id_instruc <= NOP_WORD;
            if_id_nextpc  <= 32'h0000_0000;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            pend_pc       <= pend_pc_nxt;
            pend_valid    <= pend_valid_nxt;
            if_id_instruc <= instruc_nxt;
            if_id_nextpc  <= nextpc_nxt;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: vector table plus hand sequences,
// with IF/ID expectations queued at drive time and popped after the edge.
module tb_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_if_selpcsource;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_pcimd2ext;
    logic [31:0] id_if_rega;
    logic [31:0] id_if_pcindex;
    logic        if_mc_en;
    logic [31:0] if_mc_addr;
    logic [31:0] mc_if_data;
    logic        mc_if_ready;
    logic [31:0] if_id_instruc;
    logic [31:0] if_id_nextpc;

    fetch dut (
        .clock             (clock),
        .reset             (reset),
        .id_if_selpcsource (id_if_selpcsource),
        .id_if_selpctype   (id_if_selpctype),
        .id_if_pcimd2ext   (id_if_pcimd2ext),
        .id_if_rega        (id_if_rega),
        .id_if_pcindex     (id_if_pcindex),
        .if_mc_en          (if_mc_en),
        .if_mc_addr        (if_mc_addr),
        .mc_if_data        (mc_if_data),
        .mc_if_ready       (mc_if_ready),
        .if_id_instruc     (if_id_instruc),
        .if_id_nextpc      (if_id_nextpc)
    );

    always #5 clock = ~clock;

    // Memory content is a fixed function of the address, never zero near 0.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A00_00A5;
    endfunction

    assign mc_if_data = word_of(if_mc_addr);

    typedef struct {
        logic        rdy;
        logic        src;
        logic [1:0]  typ;
        logic [31:0] exp_addr;
        logic [31:0] exp_nextpc;
        logic        exp_nop;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] nextpc;
    } exp_t;

    vec_t vecs[20];
    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input logic rdy, input logic src, input logic [1:0] typ,
                        input logic [31:0] exp_addr, input logic [31:0] exp_nextpc,
                        input logic exp_nop, input string tag);
        exp_t e;
        @(negedge clock);
        mc_if_ready       = rdy;
        id_if_selpcsource = src;
        id_if_selpctype   = typ;
        #1;
        check({tag, " en"}, {31'b0, if_mc_en}, 32'd1);
        check({tag, " addr"}, if_mc_addr, exp_addr);
        e.instr  = exp_nop ? 32'h0000_0000 : word_of(exp_addr);
        e.nextpc = exp_nextpc;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, " instruc"}, if_id_instruc, e.instr);
            check({tag, " nextpc"}, if_id_nextpc, e.nextpc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " en"}, {31'b0, if_mc_en}, 32'd0);
        check({tag, " addr"}, if_mc_addr, 32'h0);
        check({tag, " instruc"}, if_id_instruc, 32'h0);
        check({tag, " nextpc"}, if_id_nextpc, 32'h0);
        check({tag, " pend_valid"}, {31'b0, dut.pend_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        //            rdy   src   typ    addr            nextpc          nop
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0000, 32'h0000_0004, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0004, 32'h0000_0008, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0008, 32'h0000_0008, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0008, 32'h0000_0008, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0008, 32'h0000_000C, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'b00, 32'h0000_000C, 32'h0000_0010, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0000_0014, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'b00, 32'h0000_0014, 32'h0000_0018, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0100, 32'h0000_0104, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0104, 32'h0000_0108, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'b01, 32'h0000_0108, 32'h0000_0108, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 32'h0000_0108, 32'h0000_0108, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 2'b00, 32'h0000_0108, 32'h0000_0108, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 2'b00, 32'h0000_0108, 32'h0000_010C, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 2'b11, 32'h0000_0200, 32'h0000_0204, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 2'b10, 32'h0000_0040, 32'h0000_0044, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 2'b00, 32'h0040_0000, 32'h0040_0004, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 2'b00, 32'h0040_0004, 32'h0040_0004, 1'b1};
        vecs[18] = '{1'b1, 1'b1, 2'b01, 32'h0040_0004, 32'h0040_0008, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 2'b00, 32'h0000_0200, 32'h0000_0204, 1'b0};

        reset             = 1'b0;
        mc_if_ready       = 1'b0;
        id_if_selpcsource = 1'b0;
        id_if_selpctype   = 2'b00;
        id_if_pcimd2ext   = 32'h0000_0100;
        id_if_rega        = 32'h0000_0200;
        id_if_pcindex     = 32'h0040_0000;

        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");

        @(negedge clock);
        reset       = 1'b1;
        mc_if_ready = 1'b1;
        @(posedge clock);
        #1;
        check("rst_exit en", {31'b0, if_mc_en}, 32'd1);
        check("rst_exit instruc", if_id_instruc, 32'h0);

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rdy, vecs[i].src, vecs[i].typ, vecs[i].exp_addr,
                 vecs[i].exp_nextpc, vecs[i].exp_nop, $sformatf("v%0d", i));
            if (i == 10) check("v10 pend_valid", {31'b0, dut.pend_valid}, 32'd1);
        end

        // Park a pending redirect during a stall, then reset in the middle of the wait.
        @(negedge clock);
        mc_if_ready       = 1'b0;
        id_if_selpcsource = 1'b1;
        id_if_selpctype   = 2'b01;
        @(posedge clock);
        #1;
        check("stall pend_valid", {31'b0, dut.pend_valid}, 32'd1);
        @(negedge clock);
        id_if_selpcsource = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");

        @(negedge clock);
        reset       = 1'b1;
        mc_if_ready = 1'b1;
        @(posedge clock);
        #1;
        check("restart en", {31'b0, if_mc_en}, 32'd1);
        step(1'b1, 1'b0, 2'b00, 32'h0000_0000, 32'h0000_0004, 1'b0, "restart0");
        step(1'b1, 1'b0, 2'b00, 32'h0000_0004, 32'h0000_0008, 1'b0, "restart4");

        id_if_pcimd2ext = 32'hFFFF_FFFC;
        step(1'b1, 1'b1, 2'b00, 32'h0000_0008, 32'h0000_000C, 1'b0, "to_top");
        step(1'b1, 1'b0, 2'b00, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, "wrap");
        step(1'b1, 1'b0, 2'b00, 32'h0000_0000, 32'h0000_0004, 1'b0, "wrap0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low.
REQ-003 SHALL have port id_if_selpcsource, input, 1 bit: redirect request from decode (1 = take the target chosen by selpctype).
REQ-004 SHALL have port id_if_selpctype, input, 2 bits: target select (00 pcimd2ext, 01 rega, 10 pcindex, 11 exception vector).
REQ-005 SHALL have ports id_if_pcimd2ext, id_if_rega and id_if_pcindex, inputs, 32 bits each: candidate targets.
REQ-006 SHALL have port if_mc_en, output, 1 bit: instruction-memory request valid.
REQ-007 SHALL have port if_mc_addr, output, 32 bits: request address (current PC).
REQ-008 SHALL have port mc_if_data, input, 32 bits: instruction word, valid when mc_if_ready is 1.
REQ-009 SHALL have port mc_if_ready, input, 1 bit: memory completes the request in this cycle.
REQ-010 SHALL have port if_id_instruc, output reg, 32 bits: IF/ID instruction.
REQ-011 SHALL have port if_id_nextpc, output reg, 32 bits: IF/ID PC+4 of that instruction.

Function
REQ-012 SHALL implement a 2-state FSM: RST and FETCH; RST goes to FETCH on the first clock edge after reset deasserts; FETCH has no exit except reset.
REQ-013 SHALL hold if_mc_en at 0 in RST and at 1 in FETCH, with if_mc_addr equal to pc.
REQ-014 SHALL complete a fetch in FETCH with mc_if_ready=1 by loading if_id_instruc<=mc_if_data and if_id_nextpc<=pc+4, all within the same edge.
REQ-015 SHALL load if_id_instruc<=32'h0000_0000 (NOP) on each FETCH edge with mc_if_ready=0 and hold pc and if_id_nextpc.
REQ-016 SHALL select the redirect target as: selpctype 00 -> pcimd2ext, 01 -> rega, 10 -> pcindex, 11 -> 32'h0000_0040.
REQ-017 SHALL treat the instruction in flight when id_if_selpcsource=1 as the delay slot, which is delivered and never squashed.
REQ-018 SHALL, on a completing edge with id_if_selpcsource=1, load pc<=target.
REQ-019 SHALL, on a completing edge with pend_valid=1 and id_if_selpcsource=0, load pc<=pend_pc and clear pend_valid.
REQ-020 SHALL, on any other completing edge, load pc<=pc+4.
REQ-021 SHALL, on a non-completing edge with id_if_selpcsource=1, capture pend_pc<=target and set pend_valid=1; a second such capture overwrites the first.
REQ-022 SHALL give a live redirect priority over a pending one when both exist on a completing edge.
REQ-023 SHALL perform all PC arithmetic modulo 2^32 (0xFFFF_FFFC+4 wraps to 0) and perform no alignment checking.
REQ-024 SHALL have throughput of 1 instruction/cycle with mc_if_ready held at 1 and latency from address to IF/ID of one edge.

Reset
REQ-025 SHALL, while reset=0, force state=RST, pc=32'h0000_0000, pend_valid=0, pend_pc=0, if_id_instruc=0, if_id_nextpc=0, if_mc_en=0.
REQ-026 SHALL discard any in-flight request on reset asserted mid-wait and then refetch from address 0.

Structure
REQ-027 SHALL place the selpctype encodings, NOP word, reset vector (0x0) and exception vector (0x40) in a shared pipeline defines package used by decode and fetch.
REQ-028 SHALL implement target selection in one combinational sub-module named pc_select; the FSM, pc, pending register and IF/ID register stay in fetch.

Verification
REQ-029 SHALL verify that reset released with mc_if_ready=1 and memory returning addr -> if_mc_addr goes 0,4,8 on consecutive cycles, with if_id_nextpc following 4,8,12.
REQ-030 SHALL verify that mc_if_ready=0 for 2 cycles at pc=8 -> two NOPs appear in IF/ID, pc holds at 8, then the word at 8 loads with nextpc=12.
REQ-031 SHALL verify that a branch at 0x10 (selpcsource=1, selpctype=00, pcimd2ext=0x100) with ready=1 -> delay slot 0x14 is delivered, then fetch goes to 0x100.
REQ-032 SHALL verify that a redirect (selpctype=01, rega=0x200) while the delay-slot fetch stalls 3 cycles -> pend_valid=1, delay slot is delivered, next address is 0x200.
REQ-033 SHALL verify that selpctype=11 and 10 (pcindex=0x0040_0000) select 0x40 and 0x0040_0000 respectively.
REQ-034 SHALL verify that reset asserted mid-stall with pend_valid=1 -> all outputs are 0 immediately and fetch restarts at 0 with no pending redirect.
